// File: rtl/argon_pkg.sv
// argon_pkg: shared mask encodings, arbiter states and winner selection for the Argon memory arbiter
package argon_pkg;
  localparam logic [2:0] RDMASK_NONE = 3'd0;
  localparam logic [2:0] RDMASK_B    = 3'd1;
  localparam logic [2:0] RDMASK_BU   = 3'd2;
  localparam logic [2:0] RDMASK_H    = 3'd3;
  localparam logic [2:0] RDMASK_HU   = 3'd4;
  localparam logic [2:0] RDMASK_W    = 3'd5;
  localparam logic [1:0] WRMASK_NONE = 2'd0;
  localparam logic [1:0] WRMASK_B    = 2'd1;
  localparam logic [1:0] WRMASK_H    = 2'd2;
  localparam logic [1:0] WRMASK_W    = 2'd3;
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} arb_state_t;
  function automatic logic pick_winner(input logic if_req, input logic dm_req, input logic last_dm, input logic mode);
    return (dm_req && (!if_req || mode || !last_dm)) ? REQ_DM : REQ_IF;
  endfunction
endpackage

// File: rtl/argon_mem_arbiter.sv
// argon_mem_arbiter: shares the Argon memory port between fetch and data requesters over a fixed latency
module argon_mem_arbiter
  import argon_pkg::*;
#(
  parameter int MEM_LATENCY   = 1,
  parameter int PRIORITY_MODE = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_ack,
  output logic [31:0] o_if_rdata,
  input  logic        i_dm_req,
  input  logic        i_dm_we,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  input  logic [2:0]  i_dm_rd_mask,
  input  logic [1:0]  i_dm_wr_mask,
  output logic        o_dm_gnt,
  output logic        o_dm_ack,
  output logic [31:0] o_dm_rdata,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wr_data,
  output logic [2:0]  o_mem_rd_mask,
  output logic [1:0]  o_mem_wr_mask,
  input  logic [31:0] i_mem_rd_data
);
  arb_state_t state;
  logic [3:0] cnt;
  logic       r_last_dm;
  logic       w_dm;
  logic       w_we;
  logic       dm_win;
  assign dm_win = pick_winner(i_if_req, i_dm_req, r_last_dm, PRIORITY_MODE != 0);
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= S_IDLE;
      cnt           <= 4'd0;
      r_last_dm     <= 1'b1;
      w_dm          <= 1'b0;
      w_we          <= 1'b0;
      o_if_gnt      <= 1'b0;
      o_dm_gnt      <= 1'b0;
      o_if_ack      <= 1'b0;
      o_dm_ack      <= 1'b0;
      o_if_rdata    <= 32'd0;
      o_dm_rdata    <= 32'd0;
      o_mem_addr    <= 32'd0;
      o_mem_wr_data <= 32'd0;
      o_mem_rd_mask <= RDMASK_NONE;
      o_mem_wr_mask <= WRMASK_NONE;
    end else begin
      o_if_gnt <= 1'b0;
      o_dm_gnt <= 1'b0;
      o_if_ack <= 1'b0;
      o_dm_ack <= 1'b0;
      case (state)
        S_IDLE: if (i_if_req || i_dm_req) begin
          state         <= S_ACCESS;
          cnt           <= 4'(MEM_LATENCY - 1);
          r_last_dm     <= dm_win;
          w_dm          <= dm_win;
          w_we          <= dm_win && i_dm_we;
          o_if_gnt      <= !dm_win;
          o_dm_gnt      <= dm_win;
          o_mem_addr    <= dm_win ? i_dm_addr : i_if_addr & ~32'h3;
          o_mem_wr_data <= dm_win ? i_dm_wdata : 32'd0;
          o_mem_rd_mask <= !dm_win ? RDMASK_W : i_dm_we ? RDMASK_NONE : i_dm_rd_mask;
          o_mem_wr_mask <= (dm_win && i_dm_we) ? i_dm_wr_mask : WRMASK_NONE;
        end
        S_ACCESS: if (cnt == 4'd0) begin
          if (!w_dm) o_if_rdata <= i_mem_rd_data;
          if (w_dm && !w_we) o_dm_rdata <= i_mem_rd_data;
          o_if_ack      <= !w_dm;
          o_dm_ack      <= w_dm;
          o_mem_addr    <= 32'd0;
          o_mem_wr_data <= 32'd0;
          o_mem_rd_mask <= RDMASK_NONE;
          o_mem_wr_mask <= WRMASK_NONE;
          state         <= S_RESP;
        end else begin
          cnt <= cnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_argon_mem_arbiter.sv
// tb_argon_mem_arbiter: random traffic on two arbiter configurations checked against a transaction schedule model
module tb_argon_mem_arbiter;
  import argon_pkg::*;
  localparam int LAT0 = 3;
  localparam int LAT1 = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rd = '0;
  logic [2:0] dm_rm = '0;
  logic [1:0] dm_wm = '0;
  logic if_gnt[2], if_ack[2], dm_gnt[2], dm_ack[2];
  logic [31:0] if_rdata[2], dm_rdata[2], mem_addr[2], mem_wd[2];
  logic [2:0] mem_rm[2];
  logic [1:0] mem_wm[2];
  int n_chk = 0, n_pass = 0, cyc = 0;
  bit busy[2], last_dm[2], win_dm[2], win_we[2];
  int gedge[2];
  logic e_ig[2], e_ia[2], e_dg[2], e_da[2];
  logic [31:0] e_ifr[2], e_dmr[2], e_addr[2], e_wd[2];
  logic [2:0] e_rm[2];
  logic [1:0] e_wm[2];
  always #5 clk = ~clk;
  argon_mem_arbiter #(.MEM_LATENCY(LAT0), .PRIORITY_MODE(0)) u0 (
    .i_clk(clk), .i_reset(rst), .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(if_gnt[0]), .o_if_ack(if_ack[0]), .o_if_rdata(if_rdata[0]),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .i_dm_rd_mask(dm_rm), .i_dm_wr_mask(dm_wm), .o_dm_gnt(dm_gnt[0]), .o_dm_ack(dm_ack[0]),
    .o_dm_rdata(dm_rdata[0]), .o_mem_addr(mem_addr[0]), .o_mem_wr_data(mem_wd[0]),
    .o_mem_rd_mask(mem_rm[0]), .o_mem_wr_mask(mem_wm[0]), .i_mem_rd_data(mem_rd));
  argon_mem_arbiter #(.MEM_LATENCY(LAT1), .PRIORITY_MODE(1)) u1 (
    .i_clk(clk), .i_reset(rst), .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(if_gnt[1]), .o_if_ack(if_ack[1]), .o_if_rdata(if_rdata[1]),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .i_dm_rd_mask(dm_rm), .i_dm_wr_mask(dm_wm), .o_dm_gnt(dm_gnt[1]), .o_dm_ack(dm_ack[1]),
    .o_dm_rdata(dm_rdata[1]), .o_mem_addr(mem_addr[1]), .o_mem_wr_data(mem_wd[1]),
    .o_mem_rd_mask(mem_rm[1]), .o_mem_wr_mask(mem_wm[1]), .i_mem_rd_data(mem_rd));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
  endtask
  task automatic model(input int k, input int lat, input bit prio_dm);
    bit tie, dmw;
    e_ig[k] = 0; e_dg[k] = 0; e_ia[k] = 0; e_da[k] = 0;
    if (rst) begin
      busy[k] = 0; last_dm[k] = 1;
      e_ifr[k] = 0; e_dmr[k] = 0; e_addr[k] = 0; e_wd[k] = 0; e_rm[k] = RDMASK_NONE; e_wm[k] = WRMASK_NONE;
    end else if (busy[k] && cyc == gedge[k] + lat) begin
      if (!win_dm[k]) begin e_ifr[k] = mem_rd; e_ia[k] = 1; end
      else begin if (!win_we[k]) e_dmr[k] = mem_rd; e_da[k] = 1; end
      e_addr[k] = 0; e_wd[k] = 0; e_rm[k] = RDMASK_NONE; e_wm[k] = WRMASK_NONE;
    end else if (!busy[k] || cyc >= gedge[k] + lat + 2) begin
      busy[k] = 0;
      if (if_req || dm_req) begin
        tie = if_req && dm_req;
        dmw = tie ? (prio_dm ? 1'b1 : !last_dm[k]) : dm_req;
        busy[k] = 1; gedge[k] = cyc; last_dm[k] = dmw; win_dm[k] = dmw; win_we[k] = dmw && dm_we;
        if (dmw) begin
          e_dg[k] = 1; e_addr[k] = dm_addr; e_wd[k] = dm_wdata;
          e_rm[k] = dm_we ? RDMASK_NONE : dm_rm; e_wm[k] = dm_we ? dm_wm : WRMASK_NONE;
        end else begin
          e_ig[k] = 1; e_addr[k] = {if_addr[31:2], 2'b00}; e_wd[k] = 0; e_rm[k] = RDMASK_W; e_wm[k] = WRMASK_NONE;
        end
      end
    end
  endtask
  task automatic check_all(input int k);
    check($sformatf("u%0d if_gnt", k), 32'(if_gnt[k]), 32'(e_ig[k]));
    check($sformatf("u%0d if_ack", k), 32'(if_ack[k]), 32'(e_ia[k]));
    check($sformatf("u%0d dm_gnt", k), 32'(dm_gnt[k]), 32'(e_dg[k]));
    check($sformatf("u%0d dm_ack", k), 32'(dm_ack[k]), 32'(e_da[k]));
    check($sformatf("u%0d if_rdata", k), if_rdata[k], e_ifr[k]);
    check($sformatf("u%0d dm_rdata", k), dm_rdata[k], e_dmr[k]);
    check($sformatf("u%0d mem_addr", k), mem_addr[k], e_addr[k]);
    check($sformatf("u%0d mem_wd", k), mem_wd[k], e_wd[k]);
    check($sformatf("u%0d mem_rm", k), 32'(mem_rm[k]), 32'(e_rm[k]));
    check($sformatf("u%0d mem_wm", k), 32'(mem_wm[k]), 32'(e_wm[k]));
  endtask
  task automatic new_dm();
    dm_req = 1; dm_we = 1'($urandom); dm_addr = $urandom; dm_wdata = $urandom;
    dm_rm = 3'($urandom); dm_wm = 2'($urandom);
  endtask
  initial begin
    for (int c = 0; c < 3000; c++) begin
      int ph;
      @(posedge clk);
      model(0, LAT0, 1'b0);
      model(1, LAT1, 1'b1);
      cyc++;
      @(negedge clk);
      check_all(0);
      check_all(1);
      ph = (c / 500) % 3;
      rst = (c < 4) || (ph == 0 && (($urandom % 50) == 0 || (if_gnt[0] && ($urandom % 4) == 0)));
      if (if_req) begin
        if (if_gnt[0]) begin
          if (ph == 1 || ($urandom % 3) == 0) if_addr = $urandom;
          else if_req = 0;
        end
      end else if (ph == 1 || ($urandom % 4) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (dm_req) begin
        if (dm_gnt[0]) begin
          if (ph == 1 || ($urandom % 3) == 0) new_dm();
          else dm_req = 0;
        end else if (ph != 1 && ($urandom % 16) == 0) dm_req = 0;
      end else if (ph == 1 || ($urandom % 4) == 0) new_dm();
      mem_rd = $urandom;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/argon_mem_arbiter.md
Name: argon_mem_arbiter

Overview:
- Shares the single Argon memory port between two requesters: the instruction-fetch path (read-only, word) and the data path (loads/stores with byte/half/word masks).
- Sits between the Argon control unit and the memory. It sequences each access through a fixed memory latency and returns read data or a write acknowledge to the winning requester.
- Arbitration is round-robin or fixed data-priority, selected by a parameter.

Parameters:
- MEM_LATENCY, 1: cycles the memory port is held per access; read data is sampled at the end of the last held cycle; legal range 1..15.
- PRIORITY_MODE, 0: 0 = round-robin between fetch and data; 1 = data always wins a tie.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_if_req  in  1  fetch request; held until o_if_gnt
- i_if_addr  in  32  fetch byte address; bits [1:0] ignored
- o_if_gnt  out  1  one-cycle pulse: fetch access launched
- o_if_ack  out  1  one-cycle pulse: fetch complete, o_if_rdata valid
- o_if_rdata  out  32  fetch read data
- i_dm_req  in  1  data request; held until o_dm_gnt
- i_dm_we  in  1  1 = store, 0 = load
- i_dm_addr  in  32  data byte address, passed unmodified
- i_dm_wdata  in  32  store data
- i_dm_rd_mask  in  3  load mask (RDMASK_*)
- i_dm_wr_mask  in  2  store mask (WRMASK_*)
- o_dm_gnt  out  1  one-cycle pulse: data access launched
- o_dm_ack  out  1  one-cycle pulse: data access complete; o_dm_rdata valid if it was a load
- o_dm_rdata  out  32  load data
- o_mem_addr  out  32  memory address
- o_mem_wr_data  out  32  memory write data
- o_mem_rd_mask  out  3  memory read mask
- o_mem_wr_mask  out  2  memory write mask
- i_mem_rd_data  in  32  memory read data

Behaviour:
- All outputs are registered.
- Reset values:
  - o_*_gnt, o_*_ack = 0
  - o_*_rdata = 0
  - o_mem_addr = 0, o_mem_wr_data = 0
  - o_mem_rd_mask = RDMASK_NONE, o_mem_wr_mask = WRMASK_NONE
  - state = S_IDLE, latency counter = 0
  - r_last_dm = 1, so fetch wins the first tie.
- State S_IDLE:
  - If neither request is high, stay in S_IDLE with memory outputs at NONE/0.
  - If any request is high at edge N, select a winner. In cycle N+1 the block drives o_mem_* for the winner, pulses its gnt, loads the counter with MEM_LATENCY-1, and enters S_ACCESS.
- Winner selection:
  - A single requester always wins.
  - On a tie with PRIORITY_MODE=0, the requester that did not win last wins.
  - On a tie with PRIORITY_MODE=1, data wins.
  - r_last_dm is updated on every grant.
- Memory drive for a fetch winner: o_mem_addr = {i_if_addr[31:2], 2'b00}, o_mem_rd_mask = RDMASK_W, o_mem_wr_mask = WRMASK_NONE, o_mem_wr_data = 0.
- Memory drive for a data winner:
  - Load: o_mem_rd_mask = i_dm_rd_mask, o_mem_wr_mask = WRMASK_NONE.
  - Store: o_mem_wr_mask = i_dm_wr_mask, o_mem_rd_mask = RDMASK_NONE.
  - Address and wdata are latched at grant.
- State S_ACCESS:
  - o_mem_* are held stable for exactly MEM_LATENCY cycles; the counter decrements each cycle.
  - At the edge ending the cycle where counter = 0: capture i_mem_rd_data into the winner's rdata register (loads/fetches only), clear the memory masks to NONE, pulse the winner's ack for one cycle, and enter S_RESP.
- State S_RESP: one bubble cycle, then S_IDLE. Throughput is one access per MEM_LATENCY+2 cycles.
- rdata registers hold their value until the next read completion for the same requester. A store does not modify o_dm_rdata.
- The requester may change addr/data or drop req in the cycle gnt is seen; the latched copy is used.
- A request dropped before gnt launches no access and produces no ack.
- A request for a second access may be asserted while the first is in flight; it is considered in S_IDLE.
- Reset mid-access: the access is abandoned immediately, no ack is issued, and all outputs go to reset values on the next edge.
- Invalid masks (e.g. RDMASK_NONE on a load) are passed through unchanged. An ack is still issued after MEM_LATENCY cycles.

Decomposition:
- Package argon_pkg:
  - RDMASK_NONE=0, RDMASK_B=1, RDMASK_BU=2, RDMASK_H=3, RDMASK_HU=4, RDMASK_W=5
  - WRMASK_NONE=0, WRMASK_B=1, WRMASK_H=2, WRMASK_W=3
  - arb_state_t {S_IDLE, S_ACCESS, S_RESP}
  - requester id constants REQ_IF=0, REQ_DM=1
  - pure function pick_winner(if_req, dm_req, last_dm, mode)
- No sub-module; the FSM and datapath are a single module.

Test Plan:
- Reset, then i_if_req=1 with addr 0x0000_1003, MEM_LATENCY=2, memory returns 0xDEAD_BEEF:
  - o_if_gnt pulses 1 cycle after request.
  - o_mem_addr=0x0000_1000 and rd_mask=5 are held for 2 cycles.
  - o_if_ack pulses with o_if_rdata=0xDEAD_BEEF.
- Data store, addr 0x20, wdata 0x1234_5678, wr_mask=WRMASK_H:
  - o_mem_wr_mask=2 and rd_mask=0 for MEM_LATENCY cycles.
  - o_dm_ack pulses; o_dm_rdata is unchanged.
- Both requesters held high continuously with PRIORITY_MODE=0: grants alternate IF, DM, IF, DM, one grant per MEM_LATENCY+2 cycles. With PRIORITY_MODE=1, only DM is granted while both are held.
- i_reset pulsed in the 1st S_ACCESS cycle of a fetch with MEM_LATENCY=3:
  - No o_if_ack is issued.
  - Masks return to NONE the next cycle.
  - A fresh request after reset is granted normally.
- i_dm_req raised for 1 cycle while a fetch is in flight, then dropped: no data access is launched and no o_dm_ack is issued.
- MEM_LATENCY=1, back-to-back fetches: gnt-to-ack spacing is 1 cycle and the request repeat period is 3 cycles.
